// File: rtl/btb_assoc.sv
// btb_assoc: set-associative branch target buffer for the fetch-stage predictor.
//
// Fetch lookups are registered and answer one cycle after the request.
// Execute-stage resolution updates allocate, refresh or invalidate entries.
// Each set has its own round-robin victim pointer.
// An init/flush sweep clears one set per cycle before the table is usable.
//
// Ports:
//   clk                 clock; all state changes on the rising edge
//   rst                 synchronous active-high reset; restarts the sweep
//   flush_i             invalidate all entries (starts a new sweep)
//   ready_o             high once the sweep has finished
//   lookup_valid_i      fetch lookup request
//   lookup_pc_i         fetch PC
//   lookup_hit_o        registered hit for the previous-cycle request
//   lookup_target_o     registered target (0 on miss)
//   lookup_is_call_o    registered call flag (0 on miss)
//   lookup_is_return_o  registered return flag (0 on miss)
//   lookup_way_o        registered hit way (0 on miss)
//   update_valid_i      resolution update request
//   update_pc_i         resolved PC
//   update_target_i     resolved target
//   update_is_branch_i  1 = control transfer, 0 = not a branch (drop alias)
//   update_is_call_i    call flag
//   update_is_return_i  return flag
module btb_assoc #(
  parameter int unsigned ENTRIES = 2048,
  parameter int unsigned WAYS    = 2,
  localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  output logic             ready_o,
  input  logic             lookup_valid_i,
  input  logic [31:0]      lookup_pc_i,
  output logic             lookup_hit_o,
  output logic [31:0]      lookup_target_o,
  output logic             lookup_is_call_o,
  output logic             lookup_is_return_o,
  output logic [WAY_W-1:0] lookup_way_o,
  input  logic             update_valid_i,
  input  logic [31:0]      update_pc_i,
  input  logic [31:0]      update_target_i,
  input  logic             update_is_branch_i,
  input  logic             update_is_call_i,
  input  logic             update_is_return_i
);

  localparam int unsigned SETS  = ENTRIES / WAYS;
  localparam int unsigned IDX_W = (SETS > 1) ? $clog2(SETS) : 1;
  localparam int unsigned TAG_W = 30 - IDX_W;

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e           state_q;
  logic [IDX_W-1:0] sweep_q;

  logic             valid_q   [SETS][WAYS];
  logic [TAG_W-1:0] tag_q     [SETS][WAYS];
  logic [31:0]      target_q  [SETS][WAYS];
  logic             call_q    [SETS][WAYS];
  logic             ret_q     [SETS][WAYS];
  logic [WAY_W-1:0] rr_q      [SETS];

  // Instruction words are 4-byte aligned, so the low PC bits carry no information.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc_i[1:0], update_pc_i[1:0]};

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;

  assign lk_idx = (SETS > 1) ? lookup_pc_i[IDX_W+1:2] : '0;
  assign up_idx = (SETS > 1) ? update_pc_i[IDX_W+1:2] : '0;
  assign lk_tag = lookup_pc_i[31:IDX_W+2];
  assign up_tag = update_pc_i[31:IDX_W+2];

  assign ready_o = (state_q == StRun);

  // Lookup tag compare; the lowest matching way wins if several match.
  logic             lk_hit;
  logic [WAY_W-1:0] lk_way;
  logic [31:0]      lk_target;
  logic             lk_call, lk_ret;

  always_comb begin
    lk_hit    = 1'b0;
    lk_way    = '0;
    lk_target = '0;
    lk_call   = 1'b0;
    lk_ret    = 1'b0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!lk_hit && valid_q[lk_idx][w] && (tag_q[lk_idx][w] == lk_tag)) begin
        lk_hit    = 1'b1;
        lk_way    = WAY_W'(w);
        lk_target = target_q[lk_idx][w];
        lk_call   = call_q[lk_idx][w];
        lk_ret    = ret_q[lk_idx][w];
      end
    end
  end

  logic lk_fire;
  assign lk_fire = lookup_valid_i && (state_q == StRun) && lk_hit;

  // Update-side way selection: hit way, else lowest invalid way, else RR victim.
  logic             up_hit, up_inv;
  logic [WAY_W-1:0] up_hit_way, up_inv_way, up_way;

  always_comb begin
    up_hit     = 1'b0;
    up_hit_way = '0;
    up_inv     = 1'b0;
    up_inv_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!up_hit && valid_q[up_idx][w] && (tag_q[up_idx][w] == up_tag)) begin
        up_hit     = 1'b1;
        up_hit_way = WAY_W'(w);
      end
      if (!up_inv && !valid_q[up_idx][w]) begin
        up_inv     = 1'b1;
        up_inv_way = WAY_W'(w);
      end
    end
    if (up_hit) begin
      up_way = up_hit_way;
    end else if (up_inv) begin
      up_way = up_inv_way;
    end else begin
      up_way = rr_q[up_idx];
    end
  end

  // Array reads above see the pre-edge contents, giving read-before-write for
  // a lookup and an update in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= StInit;
      sweep_q            <= '0;
      lookup_hit_o       <= 1'b0;
      lookup_target_o    <= '0;
      lookup_is_call_o   <= 1'b0;
      lookup_is_return_o <= 1'b0;
      lookup_way_o       <= '0;
    end else begin
      lookup_hit_o       <= lk_fire;
      lookup_target_o    <= lk_fire ? lk_target : '0;
      lookup_is_call_o   <= lk_fire && lk_call;
      lookup_is_return_o <= lk_fire && lk_ret;
      lookup_way_o       <= lk_fire ? lk_way : '0;

      unique case (state_q)
        StInit: begin
          if (flush_i) begin
            sweep_q <= '0;
          end else begin
            for (int unsigned w = 0; w < WAYS; w++) begin
              valid_q[sweep_q][w] <= 1'b0;
            end
            rr_q[sweep_q] <= '0;
            if (sweep_q == IDX_W'(SETS - 1)) begin
              state_q <= StRun;
            end else begin
              sweep_q <= sweep_q + 1'b1;
            end
          end
        end
        StRun: begin
          if (flush_i) begin
            // Flush takes priority; a simultaneous update is discarded.
            state_q <= StInit;
            sweep_q <= '0;
          end else if (update_valid_i) begin
            if (update_is_branch_i) begin
              valid_q[up_idx][up_way]  <= 1'b1;
              tag_q[up_idx][up_way]    <= up_tag;
              target_q[up_idx][up_way] <= update_target_i;
              call_q[up_idx][up_way]   <= update_is_call_i;
              ret_q[up_idx][up_way]    <= update_is_return_i;
              // Only a true replacement advances the victim pointer.
              if (!up_hit && !up_inv && (WAYS > 1)) begin
                rr_q[up_idx] <= rr_q[up_idx] + 1'b1;
              end
            end else if (up_hit) begin
              // Resolved as non-branch: drop the stale alias.
              valid_q[up_idx][up_hit_way] <= 1'b0;
            end
          end
        end
        default: state_q <= StInit;
      endcase
    end
  end

endmodule

// File: tb/tb_btb_assoc.sv
// Directed bench for btb_assoc with ENTRIES=8, WAYS=2 (4 sets, index = pc[3:2]).
module tb_btb_assoc;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic        ready_o;
  logic        lookup_valid_i;
  logic [31:0] lookup_pc_i;
  logic        lookup_hit_o;
  logic [31:0] lookup_target_o;
  logic        lookup_is_call_o;
  logic        lookup_is_return_o;
  logic [0:0]  lookup_way_o;
  logic        update_valid_i;
  logic [31:0] update_pc_i;
  logic [31:0] update_target_i;
  logic        update_is_branch_i;
  logic        update_is_call_i;
  logic        update_is_return_i;

  always #5 clk = ~clk;

  btb_assoc #(.ENTRIES(8), .WAYS(2)) dut (
    .clk                (clk),
    .rst                (rst),
    .flush_i            (flush_i),
    .ready_o            (ready_o),
    .lookup_valid_i     (lookup_valid_i),
    .lookup_pc_i        (lookup_pc_i),
    .lookup_hit_o       (lookup_hit_o),
    .lookup_target_o    (lookup_target_o),
    .lookup_is_call_o   (lookup_is_call_o),
    .lookup_is_return_o (lookup_is_return_o),
    .lookup_way_o       (lookup_way_o),
    .update_valid_i     (update_valid_i),
    .update_pc_i        (update_pc_i),
    .update_target_i    (update_target_i),
    .update_is_branch_i (update_is_branch_i),
    .update_is_call_i   (update_is_call_i),
    .update_is_return_i (update_is_return_i)
  );

  typedef struct {
    logic        uv;
    logic [31:0] upc;
    logic [31:0] utgt;
    logic        ub, uc, ur;
    logic        lv;
    logic [31:0] lpc;
    logic        eh;
    logic [31:0] et;
    logic        ew, ec, er;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic uv, input logic [31:0] upc, input logic [31:0] utgt,
                              input logic ub, input logic uc, input logic ur,
                              input logic lv, input logic [31:0] lpc,
                              input logic eh, input logic [31:0] et,
                              input logic ew, input logic ec, input logic er);
    vec_t v;
    v.uv = uv; v.upc = upc; v.utgt = utgt; v.ub = ub; v.uc = uc; v.ur = ur;
    v.lv = lv; v.lpc = lpc;
    v.eh = eh; v.et = et; v.ew = ew; v.ec = ec; v.er = er;
    vecs.push_back(v);
  endfunction

  task automatic idle();
    flush_i = 0; lookup_valid_i = 0; lookup_pc_i = 0;
    update_valid_i = 0; update_pc_i = 0; update_target_i = 0;
    update_is_branch_i = 0; update_is_call_i = 0; update_is_return_i = 0;
  endtask

  task automatic lookup_miss(input string name, input logic [31:0] pc);
    lookup_valid_i = 1; lookup_pc_i = pc;
    @(negedge clk);
    lookup_valid_i = 0;
    chk({name, ".hit"}, 32'(lookup_hit_o), 32'd0);
    chk({name, ".tgt"}, lookup_target_o, 32'd0);
  endtask

  // Called at the negedge where the sweep-start condition was just released:
  // ready must stay low here and for three more cycles, then be high.
  task automatic expect_ready(input string name);
    chk({name, ".rdy0"}, 32'(ready_o), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("%s.rdy%0d", name, k), 32'(ready_o), 32'd0);
    end
    @(negedge clk);
    chk({name, ".rdy4"}, 32'(ready_o), 32'd1);
  endtask

  initial begin
    // Set 1 (0x104/0x114/0x124/0x134/0x144) exercises fill, replace, alias.
    //  uv upc     utgt    b  c  r  lv lpc      eh et      w  c  r
    add(1, 32'h104, 32'h200, 1, 0, 0, 0, 32'h0,   0, 32'h0,   0, 0, 0); // 0 allocate
    add(0, 32'h0,   32'h0,   0, 0, 0, 1, 32'h104, 1, 32'h200, 0, 0, 0); // 1 hit way0
    add(1, 32'h104, 32'hA,   1, 0, 0, 1, 32'h104, 1, 32'h200, 0, 0, 0); // 2 RBW overwrite
    add(1, 32'h114, 32'hB,   1, 1, 0, 1, 32'h104, 1, 32'hA,   0, 0, 0); // 3 fill way1
    add(1, 32'h124, 32'hC,   1, 0, 1, 1, 32'h114, 1, 32'hB,   1, 1, 0); // 4 replace way0
    add(0, 32'h0,   32'h0,   0, 0, 0, 1, 32'h104, 0, 32'h0,   0, 0, 0); // 5 evicted
    add(0, 32'h0,   32'h0,   0, 0, 0, 1, 32'h114, 1, 32'hB,   1, 1, 0); // 6
    add(0, 32'h0,   32'h0,   0, 0, 0, 1, 32'h124, 1, 32'hC,   0, 0, 1); // 7
    add(1, 32'h134, 32'hD,   1, 0, 0, 1, 32'h124, 1, 32'hC,   0, 0, 1); // 8 replace way1
    add(0, 32'h0,   32'h0,   0, 0, 0, 1, 32'h114, 0, 32'h0,   0, 0, 0); // 9
    add(0, 32'h0,   32'h0,   0, 0, 0, 1, 32'h134, 1, 32'hD,   1, 0, 0); // 10
    add(0, 32'h0,   32'h0,   0, 0, 0, 1, 32'h124, 1, 32'hC,   0, 0, 1); // 11
    add(1, 32'h104, 32'hE,   1, 0, 0, 0, 32'h0,   0, 32'h0,   0, 0, 0); // 12 replace way0
    add(0, 32'h0,   32'h0,   0, 0, 0, 1, 32'h104, 1, 32'hE,   0, 0, 0); // 13
    add(1, 32'h104, 32'h0,   0, 0, 0, 1, 32'h104, 1, 32'hE,   0, 0, 0); // 14 alias kill
    add(0, 32'h0,   32'h0,   0, 0, 0, 1, 32'h104, 0, 32'h0,   0, 0, 0); // 15
    add(0, 32'h0,   32'h0,   0, 0, 0, 1, 32'h134, 1, 32'hD,   1, 0, 0); // 16
    add(1, 32'h104, 32'hF,   1, 0, 0, 0, 32'h0,   0, 32'h0,   0, 0, 0); // 17 invalid way0
    add(0, 32'h0,   32'h0,   0, 0, 0, 1, 32'h104, 1, 32'hF,   0, 0, 0); // 18
    add(1, 32'h144, 32'h10,  1, 0, 0, 0, 32'h0,   0, 32'h0,   0, 0, 0); // 19 rr=1 -> way1
    add(0, 32'h0,   32'h0,   0, 0, 0, 1, 32'h134, 0, 32'h0,   0, 0, 0); // 20
    add(0, 32'h0,   32'h0,   0, 0, 0, 1, 32'h144, 1, 32'h10,  1, 0, 0); // 21
    add(0, 32'h0,   32'h0,   0, 0, 0, 1, 32'h104, 1, 32'hF,   0, 0, 0); // 22
    add(1, 32'h154, 32'h99,  0, 0, 0, 1, 32'h144, 1, 32'h10,  1, 0, 0); // 23 non-br miss
    add(0, 32'h0,   32'h0,   0, 0, 0, 1, 32'h104, 1, 32'hF,   0, 0, 0); // 24
    add(0, 32'h0,   32'h0,   0, 0, 0, 1, 32'h154, 0, 32'h0,   0, 0, 0); // 25
    add(1, 32'h108, 32'h300, 1, 0, 0, 1, 32'h108, 0, 32'h0,   0, 0, 0); // 26 same-cycle
    add(0, 32'h0,   32'h0,   0, 0, 0, 1, 32'h108, 1, 32'h300, 0, 0, 0); // 27
    add(0, 32'h0,   32'h0,   0, 0, 0, 0, 32'h108, 0, 32'h0,   0, 0, 0); // 28 no request
    add(0, 32'h0,   32'h0,   0, 0, 0, 1, 32'h10B, 1, 32'h300, 0, 0, 0); // 29 pc[1:0] ignored

    // Reset: outputs cleared even with a lookup presented.
    idle();
    rst = 1;
    lookup_valid_i = 1; lookup_pc_i = 32'h100;
    repeat (2) @(negedge clk);
    chk("rst.hit", 32'(lookup_hit_o), 32'd0);
    chk("rst.tgt", lookup_target_o, 32'd0);
    lookup_valid_i = 0;
    rst = 0;
    expect_ready("init");
    lookup_miss("post_init", 32'h100);

    foreach (vecs[i]) begin
      update_valid_i     = vecs[i].uv;
      update_pc_i        = vecs[i].upc;
      update_target_i    = vecs[i].utgt;
      update_is_branch_i = vecs[i].ub;
      update_is_call_i   = vecs[i].uc;
      update_is_return_i = vecs[i].ur;
      lookup_valid_i     = vecs[i].lv;
      lookup_pc_i        = vecs[i].lpc;
      @(negedge clk);
      chk($sformatf("v%0d.hit", i), 32'(lookup_hit_o), 32'(vecs[i].eh));
      chk($sformatf("v%0d.tgt", i), lookup_target_o, vecs[i].et);
      chk($sformatf("v%0d.way", i), 32'(lookup_way_o), 32'(vecs[i].ew));
      chk($sformatf("v%0d.call", i), 32'(lookup_is_call_o), 32'(vecs[i].ec));
      chk($sformatf("v%0d.ret", i), 32'(lookup_is_return_o), 32'(vecs[i].er));
    end
    idle();

    // Flush with a simultaneous update of 0x10C; lookups during the sweep
    // miss and an update issued mid-sweep is dropped.
    flush_i = 1;
    update_valid_i = 1; update_pc_i = 32'h10C; update_target_i = 32'h400;
    update_is_branch_i = 1;
    @(negedge clk);
    idle();
    lookup_valid_i = 1; lookup_pc_i = 32'h108;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("flush.rdy%0d", k), 32'(ready_o), 32'd0);
      if (k == 1) begin
        update_valid_i = 1; update_pc_i = 32'h118; update_target_i = 32'h500;
        update_is_branch_i = 1;
      end else begin
        update_valid_i = 0;
      end
      @(negedge clk);
      chk($sformatf("flush.hit%0d", k), 32'(lookup_hit_o), 32'd0);
    end
    idle();
    chk("flush.rdy4", 32'(ready_o), 32'd1);
    lookup_miss("flush.10c", 32'h10C);
    lookup_miss("flush.108", 32'h108);
    lookup_miss("flush.118", 32'h118);

    // Reset during the second sweep cycle restarts the sweep.
    flush_i = 1;
    @(negedge clk);
    flush_i = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    expect_ready("rst_mid");

    // A flush during the sweep also restarts it.
    flush_i = 1;
    @(negedge clk);
    flush_i = 0;
    @(negedge clk);
    flush_i = 1;
    @(negedge clk);
    flush_i = 0;
    expect_ready("flush_mid");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
